// File: rtl/sin_gen_pkg.sv
// Shared types and defaults for the sine phase sequencer.
// The run FSM states and the status counter width live here.
package sin_gen_pkg;

    localparam int DW_DEF = 16;
    localparam int ERR_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(
        input logic [ERR_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sin_phase_acc.sv
// Phase accumulator: loads a start phase and advances by a step.
// The addition wraps silently at DW bits.
module sin_phase_acc #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic [DW-1:0] init,
    input  logic [DW-1:0] step,
    output logic [DW-1:0] phase
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (load) begin
            phase <= init;
        end else if (advance) begin
            phase <= phase + step;
        end
    end

endmodule

// File: rtl/sin_seq_ctrl.sv
// Run sequencer: issues phase words to a sine generator, tracks
// outstanding words, forwards returned samples and reports status.
module sin_seq_ctrl
    import sin_gen_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             STOP,
    input  logic [DW-1:0]    FTW,
    input  logic [DW-1:0]    PHASE_INIT,
    input  logic [15:0]      NUM_SAMPLES,
    output logic             ASO_VALID,
    output logic [DW-1:0]    ASO_DATA,
    input  logic             ASO_READY,
    input  logic             ASI_VALID,
    input  logic [DW-1:0]    ASI_DATA,
    input  logic             ASI_ERROR,
    output logic             OUT_VALID,
    output logic [DW-1:0]    OUT_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT_FLAG,
    output logic [ERR_W-1:0] ERR_CNT
);

    localparam int OW = 4;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_n;
    logic [DW-1:0] ftw_q;
    logic [15:0]   num_q;
    logic [15:0]   num_eff;
    logic [15:0]   issued;
    logic [15:0]   issued_n;
    logic [OW-1:0] outst;
    logic [OW-1:0] outst_n;
    logic [TW-1:0] idle_cnt;
    logic [TW-1:0] idle_inc;
    logic          xfer;
    logic          acc;
    logic          start_ok;
    logic          tmo;
    logic          valid_n;

    sin_phase_acc #(
        .DW(DW)
    ) u_acc (
        .clk    (CLK),
        .rst    (RESET),
        .load   (start_ok),
        .advance(xfer),
        .init   (PHASE_INIT),
        .step   (ftw_q),
        .phase  (ASO_DATA)
    );

    always_comb begin
        xfer     = ASO_VALID & ASO_READY;
        // returns with nothing in flight are stray and get dropped
        acc      = ASI_VALID & (outst != '0);
        start_ok = (state == IDLE) & START;
        num_eff  = start_ok ? NUM_SAMPLES : num_q;
        issued_n = start_ok ? 16'd0 : issued + {15'd0, xfer};
        idle_inc = idle_cnt + 1'b1;

        unique case ({xfer, acc})
            2'b10:   outst_n = outst + 1'b1;
            2'b01:   outst_n = outst - 1'b1;
            default: outst_n = outst;
        endcase

        tmo = (state == DRAIN) && (outst != '0) && !acc
              && (idle_inc == TW'(TIMEOUT));

        state_n = state;
        unique case (state)
            IDLE: begin
                if (START) begin
                    state_n = (NUM_SAMPLES == 16'd0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (STOP || issued_n == num_q) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (outst == '0 || tmo) begin
                    state_n = FINISH;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // only a transfer can reduce the issue credit, so valid never
        // falls while a word is waiting unless STOP moved us out of ISSUE
        valid_n = (state_n == ISSUE) && (issued_n < num_eff)
                  && (outst_n < OW'(MAX_OUT));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            ftw_q        <= '0;
            num_q        <= '0;
            issued       <= '0;
            outst        <= '0;
            idle_cnt     <= '0;
            ASO_VALID    <= 1'b0;
            OUT_VALID    <= 1'b0;
            OUT_DATA     <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            TIMEOUT_FLAG <= 1'b0;
            ERR_CNT      <= '0;
        end else begin
            state     <= state_n;
            BUSY      <= (state_n != IDLE);
            DONE      <= (state == FINISH);
            ASO_VALID <= valid_n;
            issued    <= issued_n;
            outst     <= tmo ? '0 : outst_n;
            OUT_VALID <= acc;

            if (acc) begin
                OUT_DATA <= ASI_DATA;
            end

            if (state == DRAIN && !acc && !tmo) begin
                idle_cnt <= idle_inc;
            end else begin
                idle_cnt <= '0;
            end

            if (start_ok) begin
                ftw_q        <= FTW;
                num_q        <= NUM_SAMPLES;
                ERR_CNT      <= '0;
                TIMEOUT_FLAG <= 1'b0;
            end else begin
                if (acc && ASI_ERROR) begin
                    ERR_CNT <= sat_inc(ERR_CNT);
                end
                if (tmo) begin
                    TIMEOUT_FLAG <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sin_seq_ctrl.md
SIN_SEQ_CTRL -- requirements
Module: sin_seq_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, meaning phase and sample data width.
REQ-002 SHALL have parameter MAX_OUT, default 4, meaning the maximum number of phase words issued but not yet returned (1..15).
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the drain-idle cycle limit before abort.
REQ-004 SHALL have port CLK in 1: single clock, all logic on its rising edge.
REQ-005 SHALL have port RESET in 1: reset, asynchronous, active-high.
REQ-006 SHALL have ports START in 1 and STOP in 1: single-cycle run request and abort request.
REQ-007 SHALL have port FTW in DW: phase increment per sample.
REQ-008 SHALL have port PHASE_INIT in DW: first phase word.
REQ-009 SHALL have port NUM_SAMPLES in 16: samples per run.
REQ-010 SHALL have ports ASO_VALID out 1, ASO_DATA out DW and ASO_READY in 1: phase stream to the generator sink.
REQ-011 SHALL have ports ASI_VALID in 1, ASI_DATA in DW and ASI_ERROR in 1: sample stream from the generator source.
REQ-012 SHALL have ports OUT_VALID out 1 and OUT_DATA out DW: forwarded samples.
REQ-013 SHALL have ports BUSY out 1, DONE out 1, TIMEOUT_FLAG out 1 and ERR_CNT out 8: run status.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN and FINISH.
REQ-015 IDLE -> ISSUE on START, latching FTW, PHASE_INIT and NUM_SAMPLES; START in any other state SHALL be ignored.
REQ-016 START with NUM_SAMPLES=0 SHALL go IDLE -> FINISH and issue no phase words.
REQ-017 In ISSUE, ASO_VALID SHALL be 1 while issued<NUM_SAMPLES and outstanding<MAX_OUT.
REQ-018 A transfer SHALL occur on ASO_VALID&ASO_READY; ASO_DATA SHALL hold stable while ASO_VALID&!ASO_READY.
REQ-019 The first ASO_DATA SHALL be PHASE_INIT; each transfer SHALL advance phase by FTW modulo 2^DW (silent wrap).
REQ-020 ASO_VALID SHALL never deassert without a transfer, except on STOP or RESET.
REQ-021 ISSUE -> DRAIN when issued==NUM_SAMPLES or on STOP; STOP SHALL drop ASO_VALID in the next cycle.
REQ-022 outstanding SHALL be +1 on transfer, -1 on an ASI_VALID beat, and unchanged when both occur in the same cycle.
REQ-023 An ASI_VALID beat arriving while outstanding==0 SHALL be discarded and not forwarded.
REQ-024 Each accepted ASI_VALID beat SHALL drive OUT_VALID=1 and OUT_DATA=ASI_DATA one cycle later.
REQ-025 ASI_ERROR on an accepted beat SHALL increment ERR_CNT, saturating at 255.
REQ-026 DRAIN -> FINISH when outstanding==0.
REQ-027 While in DRAIN, an idle counter SHALL reset on every return and count otherwise; on reaching TIMEOUT it SHALL set TIMEOUT_FLAG, clear outstanding and go to FINISH.
REQ-028 FINISH SHALL pulse DONE for one cycle and then go to IDLE.
REQ-029 BUSY SHALL be 1 in every state except IDLE.
REQ-030 ERR_CNT and TIMEOUT_FLAG SHALL clear on an accepted START.
REQ-031 ASO_READY need not be connected to the generator's sink-ready output; tie it to 1 when that output is not used.

Reset
REQ-032 RESET SHALL asynchronously force IDLE and drive ASO_VALID, OUT_VALID, BUSY, DONE and TIMEOUT_FLAG to 0.
REQ-033 RESET SHALL force ASO_DATA, OUT_DATA, ERR_CNT and all counters to 0.
REQ-034 RESET mid-run SHALL abandon the run without a DONE pulse.

Structure
REQ-035 Package sin_gen_pkg SHALL hold the state enum, DW default and ERR_CNT width.
REQ-036 The phase accumulator SHALL be sub-module sin_phase_acc (load, advance, DW-bit wrap).
REQ-037 Run-length, outstanding and timeout counters SHALL remain in sin_seq_ctrl.

Verification
REQ-038 PHASE_INIT=0, FTW=0x0100, NUM_SAMPLES=4, ASO_READY=1, echo after 2 cycles -> ASO_DATA 0x0000, 0x0100, 0x0200, 0x0300; 4 OUT_VALID beats; one DONE pulse.
REQ-039 PHASE_INIT=0xFF00, FTW=0x0200, NUM_SAMPLES=3 -> ASO_DATA 0xFF00, 0x0100, 0x0300 (wrap).
REQ-040 ASO_READY low for 3 cycles mid-run -> ASO_DATA stable and ASO_VALID held high; sequence intact.
REQ-041 Returns withheld, NUM_SAMPLES=10 -> ASO_VALID drops after 4 transfers; resumes on first return.
REQ-042 NUM_SAMPLES=0 -> DONE 2 cycles after START, no ASO_VALID. STOP after 2 transfers -> DONE after 2 returns.
REQ-043 No returns after 4 issues -> TIMEOUT_FLAG=1 and DONE after 255 idle cycles. 300 ASI_ERROR beats -> ERR_CNT=255. RESET mid-run -> all outputs 0.
